// File: rtl/mem_burst_reader.sv
// Sequential burst read engine: issues len reads from base_addr, buffers the returned words, streams them out.
// Optional feature: define MEM_RD_STALL_CNT_EN to add the stall_cnt output (back-pressured cycle counter).
module mem_burst_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef MEM_RD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, issued_q, popped_q, last_idx;
  logic              inflight_q, start_acc, push, pop;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;

  assign start_acc = (state_q == S_IDLE) && start;
  assign last_idx  = len_q - LEN_W'(1);
  // A read issued last cycle will land next cycle, so it reserves a FIFO slot now.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  assign push      = mem_valid && (state_q == S_READ || state_q == S_DRAIN);
  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last    = m_valid && (popped_q == last_idx);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        mem_rd_en = (issued_q < len_q) && (occupancy < OCC_W'(FIFO_DEPTH));
        if (mem_rd_en && (issued_q == last_idx)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && m_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      mem_addr   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_rd_en;
      if (start_acc) begin
        len_q    <= len;
        issued_q <= '0;
        popped_q <= '0;
        mem_addr <= base_addr;
      end else begin
        if (mem_rd_en) begin
          issued_q <= issued_q + LEN_W'(1);
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        if (pop) popped_q <= popped_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; m_valid gates every read of it, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_data;
  end

`ifdef MEM_RD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (busy && m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed self-checking bench for mem_burst_reader with a 1-cycle-latency memory model.
// Exercises the stall counter as well when compiled with MEM_RD_STALL_CNT_EN.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] len;
  logic        busy, done, mem_rd_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic        mem_valid = 1'b0;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;
`ifdef MEM_RD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int nr, np;

  mem_burst_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
`ifdef MEM_RD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [13:0] a);
    return 32'hD000_0000 | {18'h0, a};
  endfunction

  // Memory read port: data and valid one cycle after the strobe.
  always @(posedge clk) begin
    mem_valid <= mem_rd_en;
    if (mem_rd_en) mem_data <= word_at(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge (cycle 0); returns at the falling edge of cycle 1.
  task automatic do_start(input logic [13:0] b, input logic [14:0] l);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 100 && !done; n++) @(negedge clk);
    check_bit(tag, done, 1'b1);
  endtask

  // len=4 burst with m_ready=1: reads in cycles 1-4, words in cycles 3-6, done in cycle 7.
  task automatic burst4(input logic [13:0] b, input string tag);
    logic [13:0] ea;
    do_start(b, 15'd4);
    for (int c = 1; c <= 6; c++) begin
      check_bit({tag, "_rd_en"}, mem_rd_en, c <= 4);
      if (c <= 4) begin
        ea = b + 14'(c - 1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(ea));
      end
      check_bit({tag, "_valid"}, m_valid, c >= 3);
      if (c >= 3) begin
        ea = b + 14'(c - 3);
        check({tag, "_data"}, m_data, word_at(ea));
      end
      check_bit({tag, "_last"}, m_last, c == 6);
      @(negedge clk);
    end
    check_bit({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    check_bit({tag, "_busy_after"}, busy, 1'b0);
    check_bit({tag, "_done_after"}, done, 1'b0);
  endtask

  // Tracks issued reads and accepted words of a burst against its base address.
  task automatic track(input logic [13:0] b);
    logic [13:0] ea;
    if (mem_rd_en) begin
      ea = b + 14'(nr);
      check("t5_addr", 32'(mem_addr), 32'(ea));
      nr++;
    end
    if (m_valid && m_ready) begin
      ea = b + 14'(np);
      check("t5_data", m_data, word_at(ea));
      np++;
    end
  endtask

  initial begin
    int k, rd_cnt;
    logic seen;
    logic [13:0] ea;

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_rd_en", mem_rd_en, 1'b0);
    check_bit("rst_valid", m_valid, 1'b0);
    check_bit("rst_last", m_last, 1'b0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_data", m_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst and address wrap-around.
    burst4(14'h0010, "t1");
    burst4(14'h3FFE, "t3");

    // Zero-length burst.
    do_start(14'h0030, 15'd0);
    check_bit("t4_done", done, 1'b1);
    seen = mem_rd_en | m_valid;
    @(negedge clk);
    check_bit("t4_done_after", done, 1'b0);
    check_bit("t4_busy_after", busy, 1'b0);
    seen = seen | mem_rd_en | m_valid;
    @(negedge clk);
    seen = seen | mem_rd_en | m_valid;
    check_bit("t4_no_activity", seen, 1'b0);

    // Back-pressure: 12 cycles of m_ready=0 after start.
    m_ready = 1'b0;
    do_start(14'h0040, 15'd8);
    rd_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_rd_en) rd_cnt++;
      @(negedge clk);
    end
    check("t2_rd_before_release", 32'(rd_cnt), 32'd4);
    check_bit("t2_valid_stalled", m_valid, 1'b1);
    check("t2_head_stalled", m_data, word_at(14'h0040));
    m_ready = 1'b1;
    k = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (m_valid) begin
        ea = 14'h0040 + 14'(k);
        check("t2_data", m_data, word_at(ea));
        check_bit("t2_last", m_last, k == 7);
        k++;
      end
      @(negedge clk);
    end
    check("t2_word_count", 32'(k), 32'd8);
    check_bit("t2_done", done, 1'b1);
    @(negedge clk);

    // Ignored start mid-burst, then reset mid-burst.
    do_start(14'h0080, 15'd16);
    nr = 0;
    np = 0;
    for (int n = 0; n < 30 && np < 5; n++) begin
      track(14'h0080);
      @(negedge clk);
    end
    check("t5_five_words", 32'(np), 32'd5);
    start     = 1'b1;
    base_addr = 14'h0100;
    len       = 15'd3;
    track(14'h0080);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      track(14'h0080);
      @(negedge clk);
    end
    check_bit("t5_busy_before_rst", busy, 1'b1);
    check_bit("t5_valid_before_rst", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("t5_rst_busy", busy, 1'b0);
    check_bit("t5_rst_valid", m_valid, 1'b0);
    check_bit("t5_rst_rd_en", mem_rd_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("t5_no_done_after_rst", done, 1'b0);
    do_start(14'h0020, 15'd2);
    check_bit("t5b_rd_en1", mem_rd_en, 1'b1);
    check("t5b_addr1", 32'(mem_addr), 32'h20);
    @(negedge clk);
    check_bit("t5b_rd_en2", mem_rd_en, 1'b1);
    check("t5b_addr2", 32'(mem_addr), 32'h21);
    @(negedge clk);
    check_bit("t5b_rd_en3", mem_rd_en, 1'b0);
    check("t5b_data0", m_data, word_at(14'h0020));
    check_bit("t5b_last0", m_last, 1'b0);
    @(negedge clk);
    check("t5b_data1", m_data, word_at(14'h0021));
    check_bit("t5b_last1", m_last, 1'b1);
    @(negedge clk);
    check_bit("t5b_done", done, 1'b1);
    @(negedge clk);

`ifdef MEM_RD_STALL_CNT_EN
    // Stall counter: 5 back-pressured cycles with m_valid high.
    m_ready = 1'b0;
    do_start(14'h0200, 15'd2);
    for (int n = 0; n < 20 && !m_valid; n++) @(negedge clk);
    check_bit("t6_valid_seen", m_valid, 1'b1);
    repeat (5) @(negedge clk);
    m_ready = 1'b1;
    wait_done("t6_done");
    check("t6_stall_at_done", stall_cnt, 32'd5);
    @(negedge clk);
    check("t6_stall_hold", stall_cnt, 32'd5);
    do_start(14'h0200, 15'd2);
    check("t6_stall_cleared", stall_cnt, 32'd0);
    wait_done("t6_done2");
    check("t6_stall_no_bp", stall_cnt, 32'd0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
